control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter DATA_W, default 16: width of the imm_val bus.
REQ-002 Parameter NREGS, default 8: number of general registers, which is also the width of reg_en.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 run  input  1  request to start executing the instruction presented on ir_in.
REQ-006 ir_in  input  16  instruction word: opcode[15:12], rx[11:9], ry[8:6], imm8[7:0].
REQ-007 bus_sel  output  4  drives the register/immediate bus mux select: 0-7 select R0-R7, 8 selects imm_val.
REQ-008 imm_val  output  DATA_W  zero-extended IR[7:0].
REQ-009 reg_en  output  NREGS  one-hot write enable for rx.
REQ-010 wb_src  output  1  register write-back source: 0 = bus, 1 = ALU result register G.
REQ-011 a_en, g_en  output  1 each  load enables for ALU operand register A and result register G.
REQ-012 alu_op  output  2  ALU operation: 00 add, 01 sub, 10 and.
REQ-013 busy, done, illegal  output  1 each  status outputs.
REQ-014 instr_count  output  16  count of completed instructions.

Function
REQ-015 The FSM SHALL have four states: IDLE, T1, T2, T3.
REQ-016 In IDLE with run=1, the block SHALL capture ir_in into the internal IR and go to T1; run is ignored in all other states.
REQ-017 Outputs SHALL be decoded combinationally from state and the registered IR (Moore); ir_in changes outside IDLE SHALL have no effect.
REQ-018 MV (0000), T1: bus_sel=ry, reg_en[rx]=1, wb_src=0, done=1; next state IDLE.
REQ-019 MVI (0001), T1: bus_sel=8, reg_en[rx]=1, wb_src=0, done=1; next state IDLE.
REQ-020 ADD/SUB/AND (0010/0011/0100), T1: bus_sel=rx, a_en=1; next state T2.
REQ-021 ALU op, T2: bus_sel=ry, g_en=1, alu_op per opcode; next state T3.
REQ-022 ALU op, T3: wb_src=1, reg_en[rx]=1, done=1; next state IDLE.
REQ-023 Any other opcode, T1: done=1, illegal=1, no enables asserted; next state IDLE.
REQ-024 Latency from the run-sampling edge to done SHALL be 1 cycle for MV/MVI/illegal and 3 cycles for ALU ops; done SHALL be a single-cycle pulse.
REQ-025 busy SHALL be 1 in T1, T2 and T3, and 0 in IDLE.
REQ-026 In any cycle where an output is not specified above: bus_sel=0, reg_en=0, wb_src=0, a_en=0, g_en=0, alu_op=00, done=0, illegal=0.
REQ-027 imm_val SHALL always equal zero-extended IR[7:0], independent of state.
REQ-028 instr_count SHALL increment on every cycle with done=1, illegal instructions included, and SHALL wrap from 0xFFFF to 0x0000.
REQ-029 rx == ry SHALL be legal; the sequence is unchanged (e.g. ADD R3,R3 doubles R3).
REQ-030 run held high continuously SHALL start the next instruction in the cycle after the block returns to IDLE; there is no back-to-back issue from T1 or T3.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL enter IDLE and clear IR and instr_count to 0.
REQ-032 Reset SHALL take effect mid-instruction: no done pulse and no reg_en assertion in the following cycle.
REQ-033 After reset, every output SHALL be 0 and imm_val SHALL be 0x0000.

Structure
REQ-034 A shared package cpu_pkg SHALL hold: opcode constants, the state enum, the bus_sel code for the immediate (4'd8), and the alu_op encodings.
REQ-035 Opcode-to-control decoding SHALL live in a single combinational sub-module, ir_decode; the FSM, IR and counter stay in control_unit.

Verification
REQ-036 Reset, then MVI R2,#0x5A (ir=0x145A) with run=1 -> next cycle: bus_sel=8, imm_val=0x005A, reg_en=0x04, done=1.
REQ-037 MV R5,R2 (ir=0x0A80) -> T1: bus_sel=2, reg_en=0x20, wb_src=0; instr_count +1.
REQ-038 SUB R1,R4 (ir=0x3300) -> T1: bus_sel=1, a_en=1; T2: bus_sel=4, g_en=1, alu_op=01; T3: wb_src=1, reg_en=0x02, done=1.
REQ-039 Opcode 0xF with run=1 -> one cycle later: done=1, illegal=1, reg_en=0; instr_count increments.
REQ-040 rst_n=0 during T2 of an ADD -> next cycle in IDLE, all outputs 0, no write-back.
REQ-041 Preload instr_count to 0xFFFF via 65535 MV instructions, then issue one more -> instr_count=0x0000; run toggled during busy -> ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcode constants, FSM state
// encoding, the bus_sel code that selects the immediate, and ALU op codes.
package cpu_pkg;

  // Opcodes live in ir[15:12].
  localparam logic [3:0] OP_MV  = 4'h0;
  localparam logic [3:0] OP_MVI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;

  // bus_sel 0-7 picks R0-R7; this code picks imm_val.
  localparam logic [3:0] BUS_IMM = 4'd8;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  // True for the three-step ALU instructions (T1 -> T2 -> T3).
  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic [1:0] alu_code(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ir_decode.sv
// Combinational decode of the registered instruction word and the current
// FSM state into datapath control signals (Moore outputs).
// Ports:
//   state     - current FSM state
//   ir        - registered instruction word
//   bus_sel   - bus mux select (0-7 registers, 8 immediate)
//   reg_en    - one-hot write enable for rx
//   wb_src    - write-back source (0 bus, 1 G)
//   a_en/g_en - ALU operand / result register loads
//   alu_op    - ALU operation
//   busy/done/illegal - status
//   alu_instr - opcode needs the T2/T3 steps (used by the FSM)
module ir_decode
  import cpu_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  state_t           state,
  input  logic [15:0]      ir,
  output logic [3:0]       bus_sel,
  output logic [NREGS-1:0] reg_en,
  output logic             wb_src,
  output logic             a_en,
  output logic             g_en,
  output logic [1:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             alu_instr
);

  logic [3:0]       op;
  logic [2:0]       rx;
  logic [2:0]       ry;
  logic [NREGS-1:0] rx_onehot;

  assign op = ir[15:12];
  assign rx = ir[11:9];
  assign ry = ir[8:6];

  // Register indices beyond NREGS shift out and produce no enable.
  assign rx_onehot = NREGS'(1) << rx;
  assign alu_instr = is_alu(op);

  always_comb begin
    bus_sel = 4'd0;
    reg_en  = '0;
    wb_src  = 1'b0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    alu_op  = ALU_ADD;
    done    = 1'b0;
    illegal = 1'b0;
    busy    = (state != S_IDLE);

    case (state)
      S_T1: begin
        case (op)
          OP_MV: begin
            bus_sel = {1'b0, ry};
            reg_en  = rx_onehot;
            done    = 1'b1;
          end
          OP_MVI: begin
            bus_sel = BUS_IMM;
            reg_en  = rx_onehot;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            bus_sel = {1'b0, rx};
            a_en    = 1'b1;
          end
          default: begin
            // Unknown opcode retires immediately with no enables.
            done    = 1'b1;
            illegal = 1'b1;
          end
        endcase
      end
      S_T2: begin
        if (alu_instr) begin
          bus_sel = {1'b0, ry};
          g_en    = 1'b1;
          alu_op  = alu_code(op);
        end
      end
      S_T3: begin
        if (alu_instr) begin
          wb_src = 1'b1;
          reg_en = rx_onehot;
          done   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit for a small register/ALU datapath. Holds the
// instruction register, the four-state sequencer and a retired-instruction
// counter; control outputs are decoded from state and IR by ir_decode.
//
// Handshake: run acts as a valid strobe and busy as the inverse of ready.
// An instruction on ir_in is accepted only at a clock edge where the unit
// is in IDLE (busy=0) and run=1; run and ir_in are ignored while busy=1.
//
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   run, ir_in   - start request and instruction word
//   bus_sel, imm_val, reg_en, wb_src, a_en, g_en, alu_op - datapath controls
//   busy, done, illegal - status; done pulses once per retired instruction
//   instr_count  - retired instruction count (wraps at 16 bits)
//   dbg_state    - current sequencer state
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [15:0]       ir_in,
  output logic [3:0]        bus_sel,
  output logic [DATA_W-1:0] imm_val,
  output logic [NREGS-1:0]  reg_en,
  output logic              wb_src,
  output logic              a_en,
  output logic              g_en,
  output logic [1:0]        alu_op,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [15:0]       instr_count,
  output state_t            dbg_state
);

  state_t      state;
  logic [15:0] ir;
  logic        alu_instr;

  assign dbg_state = state;
  assign imm_val   = DATA_W'(ir[7:0]);

  ir_decode #(.NREGS(NREGS)) u_decode (
    .state     (state),
    .ir        (ir),
    .bus_sel   (bus_sel),
    .reg_en    (reg_en),
    .wb_src    (wb_src),
    .a_en      (a_en),
    .g_en      (g_en),
    .alu_op    (alu_op),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal),
    .alu_instr (alu_instr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            ir    <= ir_in;
            state <= S_T1;
          end
        end
        S_T1:    state <= alu_instr ? S_T2 : S_IDLE;
        S_T2:    state <= S_T3;
        S_T3:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Counts every done cycle, illegal instructions included; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if (done) begin
      instr_count <= instr_count + 16'd1;
    end
  end

endmodule
